// File: rtl/shift_chain_sched_if.sv
// Bus bundle between the chain sequencer and its requesters/chains.
// The sequencer takes the slave modport; the requester side takes master.
interface shift_chain_sched_if #(
  parameter int BITS = 16
);
  logic [1:0]      i_req;
  logic [1:0]      i_q;
  logic            o_shld;
  logic            o_serclk;
  logic [1:0]      o_gnt;
  logic            o_busy;
  logic [1:0]      o_done;
  logic [BITS-1:0] o_data;

  modport master (
    output i_req, i_q,
    input  o_shld, o_serclk, o_gnt, o_busy, o_done, o_data
  );

  modport slave (
    input  i_req, i_q,
    output o_shld, o_serclk, o_gnt, o_busy, o_done, o_data
  );
endinterface

// File: rtl/shift_chain_sched.sv
// Shared 74LS165 load/shift sequencer with round-robin arbitration between the
// address (0) and data (1) chains. Optional burst re-grant: SHIFT_CHAIN_BURST_EN.
module shift_chain_sched #(
  parameter int BITS     = 16,
  parameter int LOAD_CYC = 2,
  parameter int HALF_CYC = 1
) (
  input  logic               clk,
  input  logic               reset,
  shift_chain_sched_if.slave bus_if
);

  typedef enum logic [2:0] {IDLE, LOAD, SLOW, SHIGH, DONE} state_e;

  localparam int CW   = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int TMAX = (LOAD_CYC > HALF_CYC) ? LOAD_CYC : HALF_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(BITS - 1);
  localparam logic [TW-1:0] LOAD_LAST = TW'(LOAD_CYC - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_CYC - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            ptr_q, ptr_d;
  logic [BITS-1:0] shreg_q, shreg_d;
  logic [BITS-1:0] data_q, data_d;

  logic [1:0] win;
  logic       gidx;
  logic       q_bit;

  assign gidx  = gnt_q[1];
  assign q_bit = bus_if.i_q[gidx];

  // ptr_q = 1 means requester 1 wins a tie
  always_comb begin
    case (bus_if.i_req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = ptr_q ? 2'b10 : 2'b01;
      default: win = 2'b00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (win != 2'b00) begin
          gnt_d   = win;
          tmr_d   = '0;
          state_d = LOAD;
          if (bus_if.i_req == 2'b11) ptr_d = win[0];
        end
      end
      LOAD: begin
        cnt_d = '0;
        if (tmr_q == LOAD_LAST) begin
          tmr_d   = '0;
          state_d = SLOW;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      SLOW: begin
        if (tmr_q == HALF_LAST) begin
          shreg_d = {shreg_q[BITS-2:0], q_bit};
          tmr_d   = '0;
          state_d = (cnt_q == CNT_LAST) ? DONE : SHIGH;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      SHIGH: begin
        if (tmr_q == HALF_LAST) begin
          cnt_d   = cnt_q + CW'(1);
          tmr_d   = '0;
          state_d = SLOW;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      DONE: begin
        data_d = shreg_q;
`ifdef SHIFT_CHAIN_BURST_EN
        // sole requester still asking: reload without an idle gap
        if (bus_if.i_req[gidx] && !bus_if.i_req[~gidx]) begin
          tmr_d   = '0;
          state_d = LOAD;
        end else begin
          gnt_d   = 2'b00;
          state_d = IDLE;
        end
`else
        gnt_d   = 2'b00;
        state_d = IDLE;
`endif
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      ptr_q   <= 1'b0;
      shreg_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
    end
  end

  assign bus_if.o_shld   = (state_q != LOAD);
  assign bus_if.o_serclk = (state_q == SHIGH);
  assign bus_if.o_gnt    = gnt_q;
  assign bus_if.o_busy   = (state_q != IDLE);
  assign bus_if.o_done   = (state_q == DONE) ? gnt_q : 2'b00;
  assign bus_if.o_data   = data_q;

endmodule

// File: tb/tb_shift_chain_sched.sv
// Bench for shift_chain_sched: default instance (a) plus BITS=8/HALF_CYC=2 instance (b),
// with behavioural 74LS165 chain models and a round-robin reference.
module tb_shift_chain_sched;
  localparam int BA = 16, LA = 2, HA = 1;
  localparam int BB = 8,  LB = 2, HB = 2;
  localparam int LAT_A = LA + (2*BA - 1)*HA + 1;
  localparam int LAT_B = LB + (2*BB - 1)*HB + 1;
`ifdef SHIFT_CHAIN_BURST_EN
  localparam int EXP_WAIT_B = 1;
`else
  localparam int EXP_WAIT_B = 2;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  shift_chain_sched_if #(.BITS(BA)) bus_a ();
  shift_chain_sched_if #(.BITS(BB)) bus_b ();

  shift_chain_sched #(.BITS(BA), .LOAD_CYC(LA), .HALF_CYC(HA)) dut_a (
    .clk(clk), .reset(reset), .bus_if(bus_a)
  );
  shift_chain_sched #(.BITS(BB), .LOAD_CYC(LB), .HALF_CYC(HB)) dut_b (
    .clk(clk), .reset(reset), .bus_if(bus_b)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0]      req_v [2];
  logic [BA-1:0]   wa0, wa1;
  logic [BB-1:0]   wb0, wb1;
  logic [1:0][BA-1:0] ch_a;
  logic [1:0][BB-1:0] ch_b;
  logic pa = 1'b0, pb = 1'b0;
  int   rises [2];

  assign bus_a.i_req = req_v[0];
  assign bus_b.i_req = req_v[1];
  assign bus_a.i_q   = {ch_a[1][BA-1], ch_a[0][BA-1]};
  assign bus_b.i_q   = {ch_b[1][BB-1], ch_b[0][BB-1]};

  // Chain model: parallel load while shld low, shift toward QH on each serclk rise.
  always @(negedge clk) begin
    if (!bus_a.o_shld) ch_a = {wa1, wa0};
    else if (bus_a.o_serclk && !pa) begin
      ch_a[0] = {ch_a[0][BA-2:0], 1'b0};
      ch_a[1] = {ch_a[1][BA-2:0], 1'b0};
      rises[0] = rises[0] + 1;
    end
    pa = bus_a.o_serclk;
    if (!bus_b.o_shld) ch_b = {wb1, wb0};
    else if (bus_b.o_serclk && !pb) begin
      ch_b[0] = {ch_b[0][BB-2:0], 1'b0};
      ch_b[1] = {ch_b[1][BB-2:0], 1'b0};
      rises[1] = rises[1] + 1;
    end
    pb = bus_b.o_serclk;
  end

  logic [1:0]  busy_w, shld_w, ser_w;
  logic [1:0]  gnt_w [2];
  logic [1:0]  done_w [2];
  logic [31:0] data_w [2];
  assign busy_w    = {bus_b.o_busy, bus_a.o_busy};
  assign shld_w    = {bus_b.o_shld, bus_a.o_shld};
  assign ser_w     = {bus_b.o_serclk, bus_a.o_serclk};
  assign gnt_w[0]  = bus_a.o_gnt;
  assign gnt_w[1]  = bus_b.o_gnt;
  assign done_w[0] = bus_a.o_done;
  assign done_w[1] = bus_b.o_done;
  assign data_w[0] = 32'(bus_a.o_data);
  assign data_w[1] = 32'(bus_b.o_data);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_shld"},   32'(bus_a.o_shld),   32'd1);
    chk({tag, "_serclk"}, 32'(bus_a.o_serclk), 32'd0);
    chk({tag, "_gnt"},    32'(bus_a.o_gnt),    32'd0);
    chk({tag, "_busy"},   32'(bus_a.o_busy),   32'd0);
    chk({tag, "_done"},   32'(bus_a.o_done),   32'd0);
    chk({tag, "_data"},   data_w[0],           32'd0);
  endtask

  // Runs one transaction on instance s. Cycle 1 is the first busy cycle; returns
  // at the negedge of the cycle showing o_done. drop_at>0 releases the request at
  // that cycle or at done, whichever comes first; drop_at=0 keeps it held.
  task automatic txn(input int s, input int drop_at, output int waitn, output int lat,
                     output logic [1:0] g, output logic [1:0] d, output int nr, output int nsh);
    int r0;
    waitn = 0;
    do begin @(negedge clk); waitn++; end while (!busy_w[s] && waitn < 50);
    r0  = rises[s];
    g   = gnt_w[s];
    lat = 1;
    nsh = shld_w[s] ? 0 : 1;
    while (done_w[s] == 2'b00 && lat < 400) begin
      if (drop_at > 0 && lat >= drop_at) req_v[s] = 2'b00;
      @(negedge clk);
      lat++;
      if (!shld_w[s]) nsh++;
    end
    if (drop_at > 0) req_v[s] = 2'b00;
    d  = done_w[s];
    nr = rises[s] - r0;
  endtask

  initial begin
    int wn, lat, nr, nsh, n, cyc, nd, r0, win;
    logic [1:0] g, d, pat;
    logic ptr_m;
    logic [BB-1:0] wb_next;
    logic [31:0] exp_dat;

    rises[0] = 0; rises[1] = 0;
    req_v[0] = 2'b00; req_v[1] = 2'b00;
    wa0 = '0; wa1 = '0; wb0 = '0; wb1 = '0;
    ptr_m = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    chk("rst_b_busy", 32'(busy_w[1]), 32'd0);
    reset = 1'b0;

    // requester 0 alone
    wa0 = 16'haa55; wa1 = 16'h5a5a; req_v[0] = 2'b01;
    txn(0, 999, wn, lat, g, d, nr, nsh);
    chk("t1_gnt", 32'(g), 32'h1);
    chk("t1_done", 32'(d), 32'h1);
    chk("t1_lat", 32'(lat), 32'(LAT_A));
    chk("t1_rises", 32'(nr), 32'(BA - 1));
    chk("t1_shld_low", 32'(nsh), 32'(LA));
    @(negedge clk);
    chk("t1_data", data_w[0], 32'haa55);
    chk("t1_idle_gap", 32'(busy_w[0]), 32'd0);

    // both requesting from the first cycle after reset, held for 4 transactions
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; ptr_m = 1'b0;
    wa0 = 16'haa55; wa1 = 16'h1234; req_v[0] = 2'b11;
    for (int k = 0; k < 4; k++) begin
      txn(0, (k == 3) ? 999 : 0, wn, lat, g, d, nr, nsh);
      win = ptr_m ? 1 : 0;
      ptr_m = (win == 0);
      chk($sformatf("t2_gnt%0d", k), 32'(g), 32'(1 << win));
      chk($sformatf("t2_done%0d", k), 32'(d), 32'(1 << win));
      chk($sformatf("t2_lat%0d", k), 32'(lat), 32'(LAT_A));
      @(negedge clk);
      chk($sformatf("t2_data%0d", k), data_w[0], win ? 32'h1234 : 32'haa55);
      chk($sformatf("t2_gap%0d", k), 32'(busy_w[0]), 32'd0);
    end

    // requester 1 drops its request mid-transfer
    wa1 = 16'h0ff0; req_v[0] = 2'b10;
    txn(0, 10, wn, lat, g, d, nr, nsh);
    chk("t3_gnt", 32'(g), 32'h2);
    chk("t3_done", 32'(d), 32'h2);
    chk("t3_lat", 32'(lat), 32'(LAT_A));
    @(negedge clk);
    chk("t3_data", data_w[0], 32'h0ff0);

    // reset during the 8th low serclk phase
    wa0 = 16'h6c39; req_v[0] = 2'b01; n = 0;
    do begin @(negedge clk); n++; end while (!busy_w[0] && n < 50);
    r0 = rises[0]; cyc = 1;
    while (cyc < LA + 15*HA) begin @(negedge clk); cyc++; end
    chk("t4_pre_rises", 32'(rises[0] - r0), 32'd7);
    chk("t4_pre_serclk", 32'(ser_w[0]), 32'd0);
    chk("t4_pre_busy", 32'(busy_w[0]), 32'd1);
    reset = 1'b1; req_v[0] = 2'b00;
    @(negedge clk);
    chk_reset("t4_rst");
    reset = 1'b0; ptr_m = 1'b0; nd = 0;
    repeat (45) begin @(negedge clk); if (done_w[0] != 2'b00) nd++; end
    chk("t4_no_done", 32'(nd), 32'd0);
    chk("t4_data_held", data_w[0], 32'd0);
    wa0 = 16'hc3a5; req_v[0] = 2'b01;
    txn(0, 999, wn, lat, g, d, nr, nsh);
    chk("t4_new_done", 32'(d), 32'h1);
    chk("t4_new_lat", 32'(lat), 32'(LAT_A));
    @(negedge clk);
    chk("t4_new_data", data_w[0], 32'hc3a5);

    // randomized request patterns against the round-robin reference
    for (int k = 0; k < 12; k++) begin
      pat = 2'($urandom_range(1, 3));
      wa0 = 16'($urandom); wa1 = 16'($urandom);
      if (pat == 2'b11) begin
        win = ptr_m ? 1 : 0;
        ptr_m = (win == 0);
      end else begin
        win = (pat == 2'b10) ? 1 : 0;
      end
      exp_dat = win ? 32'(wa1) : 32'(wa0);
      req_v[0] = pat;
      txn(0, 999, wn, lat, g, d, nr, nsh);
      chk($sformatf("rnd%0d_gnt", k), 32'(g), 32'(1 << win));
      chk($sformatf("rnd%0d_done", k), 32'(d), 32'(1 << win));
      chk($sformatf("rnd%0d_lat", k), 32'(lat), 32'(LAT_A));
      @(negedge clk);
      chk($sformatf("rnd%0d_data", k), data_w[0], exp_dat);
    end

    // BITS=8, HALF_CYC=2 instance with requester 0 held across two transactions
    wb0 = 8'h81; wb1 = 8'h7e; req_v[1] = 2'b01;
    txn(1, 0, wn, lat, g, d, nr, nsh);
    chk("b1_gnt", 32'(g), 32'h1);
    chk("b1_done", 32'(d), 32'h1);
    chk("b1_lat", 32'(lat), 32'(LAT_B));
    chk("b1_rises", 32'(nr), 32'(BB - 1));
    chk("b1_shld_low", 32'(nsh), 32'(LB));
    wb_next = 8'($urandom);
    wb0 = wb_next;
    txn(1, 999, wn, lat, g, d, nr, nsh);
    chk("b2_wait", 32'(wn), 32'(EXP_WAIT_B));
    chk("b2_done", 32'(d), 32'h1);
    chk("b2_lat", 32'(lat), 32'(LAT_B));
    chk("b1_data", data_w[1], 32'h81);
    @(negedge clk);
    chk("b2_data", data_w[1], 32'(wb_next));
    chk("b2_idle", 32'(busy_w[1]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
